alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter_if.sv | 51 +++++
 rtl/alu_iter.sv | 178 +++++++++++++++++
 tb/tb_alu_iter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_if.sv
// alu_iter_if: request/response bundle for the iterative ALU, plus the shared opcode enum.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports (master = requester/consumer, slave = alu_iter):
//   in_valid/in_ready, a, b, opcode, use_carry, carry_in  -> request
//   out_valid/out_ready, result, flags                    -> response

package alu_iter_pkg;
  // Encodings 11..15 are unassigned; the ALU answers them with result=0, flags=0.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SLA = 4'd7,
    OP_SRA = 4'd8,
    OP_ROL = 4'd9,
    OP_ROR = 4'd10
  } alu_op;
endpackage

interface alu_iter_if #(
  parameter int ALU_WIDTH = 8
);
  import alu_iter_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [ALU_WIDTH-1:0] a;
  logic [ALU_WIDTH-1:0] b;
  alu_op                opcode;
  logic                 use_carry;
  logic                 carry_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [ALU_WIDTH-1:0] result;
  logic [7:0]           flags;

  modport master (
    output in_valid, a, b, opcode, use_carry, carry_in, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, opcode, use_carry, carry_in, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_iter.sv
// alu_iter: 8-bit-style ALU with single-cycle arith/logic and one-bit-per-cycle shifts/rotates.
// Latency: arith/logic/n=0 shifts reach DONE on the accept edge; shifts/rotates spend n EXEC cycles.
// Backpressure: in_ready only in IDLE; result/flags held in DONE until out_ready.
// Ports: clk, rst (async, active high), bus (alu_iter_if.slave: request, response, flags
//        [7]S [6]Z [5]0 [4]H [3]0 [2]P/V [1]N [0]C).

module alu_iter #(
  parameter int ALU_WIDTH = 8,
  parameter int CNT_WIDTH = $clog2(ALU_WIDTH) + 1
) (
  input logic       clk,
  input logic       rst,
  alu_iter_if.slave bus
);
  import alu_iter_pkg::*;

  localparam int HW = ALU_WIDTH / 2;
  localparam logic [ALU_WIDTH-1:0] W_VEC = ALU_WIDTH'(ALU_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ALU_WIDTH-1:0] result_q, result_d;
  logic [7:0]           flags_q, flags_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  alu_op                op_q, op_d;

  // Datapath terms derived from the live request (only consumed on the accept edge).
  logic                 cin;
  logic [ALU_WIDTH:0]   add_ext, sub_ext;
  logic [HW:0]          add_half, sub_half;
  logic                 add_v, sub_v;
  logic [ALU_WIDTH-1:0] logic_res;
  logic [ALU_WIDTH-1:0] n_full;
  // One-bit step of the operation in flight.
  logic [ALU_WIDTH-1:0] step_res;
  logic                 step_out;

  function automatic logic [7:0] pack_flags(input logic [ALU_WIDTH-1:0] r, input logic h,
                                            input logic pv, input logic n, input logic c);
    return {r[ALU_WIDTH-1], (r == '0), 1'b0, h, 1'b0, pv, n, c};
  endfunction

  always_comb begin
    cin      = bus.use_carry & bus.carry_in;
    add_ext  = {1'b0, bus.a} + {1'b0, bus.b} + {{ALU_WIDTH{1'b0}}, cin};
    sub_ext  = {1'b0, bus.a} - {1'b0, bus.b} - {{ALU_WIDTH{1'b0}}, cin};
    // H is the carry/borrow out of the low half, so recompute that half on its own.
    add_half = {1'b0, bus.a[HW-1:0]} + {1'b0, bus.b[HW-1:0]} + {{HW{1'b0}}, cin};
    sub_half = {1'b0, bus.a[HW-1:0]} - {1'b0, bus.b[HW-1:0]} - {{HW{1'b0}}, cin};
    add_v    = (bus.a[ALU_WIDTH-1] == bus.b[ALU_WIDTH-1]) &&
               (add_ext[ALU_WIDTH-1] != bus.a[ALU_WIDTH-1]);
    sub_v    = (bus.a[ALU_WIDTH-1] != bus.b[ALU_WIDTH-1]) &&
               (sub_ext[ALU_WIDTH-1] != bus.a[ALU_WIDTH-1]);

    case (bus.opcode)
      OP_AND:  logic_res = bus.a & bus.b;
      OP_OR:   logic_res = bus.a | bus.b;
      default: logic_res = bus.a ^ bus.b;
    endcase

    // Rotates wrap the count; shifts saturate it since more than W steps changes nothing.
    if (bus.opcode == OP_ROL || bus.opcode == OP_ROR) begin
      n_full = bus.b % W_VEC;
    end else begin
      n_full = (bus.b >= W_VEC) ? W_VEC : bus.b;
    end
  end

  always_comb begin
    case (op_q)
      OP_SRL: begin
        step_res = {1'b0, result_q[ALU_WIDTH-1:1]};
        step_out = result_q[0];
      end
      OP_SRA: begin
        step_res = {result_q[ALU_WIDTH-1], result_q[ALU_WIDTH-1:1]};
        step_out = result_q[0];
      end
      OP_ROL: begin
        step_res = {result_q[ALU_WIDTH-2:0], result_q[ALU_WIDTH-1]};
        step_out = result_q[ALU_WIDTH-1];
      end
      OP_ROR: begin
        step_res = {result_q[0], result_q[ALU_WIDTH-1:1]};
        step_out = result_q[0];
      end
      default: begin // SLL and SLA behave identically
        step_res = {result_q[ALU_WIDTH-2:0], 1'b0};
        step_out = result_q[ALU_WIDTH-1];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.opcode;
          state_d = S_DONE;
          case (bus.opcode)
            OP_ADD: begin
              result_d = add_ext[ALU_WIDTH-1:0];
              flags_d  = pack_flags(add_ext[ALU_WIDTH-1:0], add_half[HW], add_v,
                                    1'b0, add_ext[ALU_WIDTH]);
            end
            OP_SUB: begin
              result_d = sub_ext[ALU_WIDTH-1:0];
              flags_d  = pack_flags(sub_ext[ALU_WIDTH-1:0], sub_half[HW], sub_v,
                                    1'b1, sub_ext[ALU_WIDTH]);
            end
            OP_AND, OP_OR, OP_XOR: begin
              result_d = logic_res;
              flags_d  = pack_flags(logic_res, (bus.opcode == OP_AND), ~^logic_res,
                                    1'b0, 1'b0);
            end
            OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROL, OP_ROR: begin
              // result_q doubles as the shift register while in EXEC.
              result_d = bus.a;
              if (n_full == '0) begin
                flags_d = pack_flags(bus.a, 1'b0, ~^bus.a, 1'b0, 1'b0);
              end else begin
                cnt_d   = n_full[CNT_WIDTH-1:0];
                state_d = S_EXEC;
              end
            end
            default: begin
              result_d = '0;
              flags_d  = '0;
            end
          endcase
        end
      end
      S_EXEC: begin
        result_d = step_res;
        cnt_d    = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          flags_d = pack_flags(step_res, 1'b0, ~^step_res, 1'b0, step_out);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed and random checks of alu_iter against an arithmetic reference model.
// Latency: measured as extra clock edges after the accept edge until out_valid is seen.
// Backpressure: exercises out_ready hold-off in DONE and asynchronous reset mid-EXEC.

module tb_alu_iter;
  import alu_iter_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_iter_if #(.ALU_WIDTH(8)) bus ();

  alu_iter #(.ALU_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sx8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reference: plain integer arithmetic on 8-bit values. lat = extra edges after accept.
  function automatic void model(input int op, input int a, input int b, input int uc,
                                input int ci, output int res, output int fl, output int lat);
    int c, h, pv, nf, n, r, s, cin;
    c = 0; h = 0; pv = 0; nf = 0; lat = 0; r = 0;
    cin = (uc != 0) ? ci : 0;
    case (op)
      0: begin
        r  = a + b + cin;
        c  = (r > 255) ? 1 : 0;
        h  = (((a & 15) + (b & 15) + cin) > 15) ? 1 : 0;
        s  = sx8(a) + sx8(b) + cin;
        pv = (s > 127 || s < -128) ? 1 : 0;
      end
      1: begin
        r  = a - b - cin;
        c  = (r < 0) ? 1 : 0;
        h  = (((a & 15) - (b & 15) - cin) < 0) ? 1 : 0;
        s  = sx8(a) - sx8(b) - cin;
        pv = (s > 127 || s < -128) ? 1 : 0;
        nf = 1;
      end
      2: begin r = a & b; h = 1; end
      3: r = a | b;
      4: r = a ^ b;
      5, 6, 7, 8, 9, 10: begin
        n   = (op >= 9) ? (b % 8) : ((b > 8) ? 8 : b);
        lat = n;
        case (op)
          6:       begin r = a >> n; c = (n > 0) ? ((a >> (n - 1)) & 1) : 0; end
          8:       begin s = sx8(a); r = s >>> n; c = (n > 0) ? ((s >>> (n - 1)) & 1) : 0; end
          9:       begin r = ((a << n) | (a >> (8 - n))) & 255; c = (n > 0) ? (r & 1) : 0; end
          10:      begin r = ((a >> n) | (a << (8 - n))) & 255; c = (n > 0) ? ((r >> 7) & 1) : 0; end
          default: begin r = a << n; c = (n > 0) ? ((a >> (8 - n)) & 1) : 0; end
        endcase
      end
      default: r = 0;
    endcase
    res = r & 255;
    if (op >= 2 && op <= 10) pv = ($countones(res) % 2 == 0) ? 1 : 0;
    fl = ((res >> 7) << 7) | ((res == 0 ? 1 : 0) << 6) | (h << 4) | (pv << 2) | (nf << 1) | c;
    if (op > 10) fl = 0;
  endfunction

  task automatic run_op(input int op, input int a, input int b, input int uc, input int ci,
                        output int res_o, output int fl_o, output int lat_o);
    int er, ef, el, lat;
    logic [3:0] op4;
    model(op, a, b, uc, ci, er, ef, el);
    op4 = op[3:0];
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a[7:0];
    bus.b         = b[7:0];
    bus.opcode    = alu_op'(op4);
    bus.use_carry = uc[0];
    bus.carry_in  = ci[0];
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", lat, el);
    check_eq("result", 32'(bus.result), er);
    check_eq("flags", 32'(bus.flags), ef);
    res_o = bus.result;
    fl_o  = bus.flags;
    lat_o = lat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("in_ready_after_done", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, f, l, er, ef, el, op, a, b;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.opcode    = OP_ADD;
    bus.use_carry = 1'b0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check_eq("rst_in_ready", 32'(bus.in_ready), 1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_result", 32'(bus.result), 0);
    check_eq("rst_flags", 32'(bus.flags), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-derived constants.
    run_op(0, 8'h07, 8'h07, 0, 0, r, f, l);
    check_eq("add77_res", r, 8'h0E); check_eq("add77_flg", f, 8'h00); check_eq("add77_lat", l, 0);
    run_op(1, 8'h07, 8'h07, 0, 0, r, f, l);
    check_eq("sub77_res", r, 8'h00); check_eq("sub77_flg", f, 8'h42);
    run_op(0, 8'hFF, 8'h01, 0, 0, r, f, l);
    check_eq("addff_res", r, 8'h00); check_eq("addff_flg", f, 8'h51);
    run_op(8, 8'hCA, 3, 0, 0, r, f, l);
    check_eq("sra_res", r, 8'hF9); check_eq("sra_flg", f, 8'h84); check_eq("sra_lat", l, 3);
    run_op(5, 8'h0F, 9, 0, 0, r, f, l);
    check_eq("sll9_res", r, 8'h00); check_eq("sll9_flg", f, 8'h45); check_eq("sll9_lat", l, 8);
    run_op(9, 8'h80, 10, 0, 0, r, f, l);
    check_eq("rol10_res", r, 8'h02); check_eq("rol10_lat", l, 2);
    run_op(0, 8'h7F, 8'h00, 1, 1, r, f, l);
    check_eq("adc_res", r, 8'h80); check_eq("adc_flg", f, 8'h94);
    run_op(6, 8'hA5, 0, 0, 0, r, f, l);
    check_eq("srl0_res", r, 8'hA5); check_eq("srl0_lat", l, 0);
    run_op(13, 8'h55, 8'h66, 0, 0, r, f, l);
    check_eq("badop_res", r, 0); check_eq("badop_flg", f, 0);

    // Hold result in DONE while the requester keeps presenting new work.
    model(0, 8'h3C, 8'h55, 0, 0, er, ef, el);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 8'h3C; bus.b = 8'h55; bus.opcode = OP_ADD;
    bus.use_carry = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_eq("hold_valid0", 32'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      bus.opcode   = OP_SUB;
      @(posedge clk);
      #1;
      check_eq("hold_result", 32'(bus.result), er);
      check_eq("hold_flags", 32'(bus.flags), ef);
      check_eq("hold_in_ready", 32'(bus.in_ready), 0);
      check_eq("hold_out_valid", 32'(bus.out_valid), 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("hold_release_rdy", 32'(bus.in_ready), 1);
    check_eq("hold_release_vld", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // Asynchronous reset in the 4th EXEC cycle of an 8-step SRL.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 8'hCA; bus.b = 8'd8; bus.opcode = OP_SRL;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 32'(bus.out_valid), 0);
    check_eq("arst_result", 32'(bus.result), 0);
    check_eq("arst_flags", 32'(bus.flags), 0);
    check_eq("arst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 8'h12, 8'h34, 0, 0, r, f, l);
    check_eq("post_rst_add", r, 8'h46);

    // Random sweep, including unassigned opcodes and over-range shift counts.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = (op >= 5 && op <= 10) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      run_op(op, a, b, $urandom_range(0, 1), $urandom_range(0, 1), r, f, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
